// File: rtl/ysyx_041514_alu_shift_pipe.sv
// Pipelined shift/rotate unit: a single left barrel (right ops via bit reversal)
// spread over STAGES registers behind a valid/ready handshake with flush.
module ysyx_041514_alu_shift_pipe #(
  parameter int XLEN    = 64,
  parameter int STAGES  = 2,
  parameter int TAG_W   = 5,
  parameter int WORD_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [2:0]              in_op_i,
  input  logic                    in_word_i,
  input  logic [XLEN-1:0]         in_num_i,
  input  logic [$clog2(XLEN)-1:0] in_count_i,
  input  logic [TAG_W-1:0]        in_tag_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [XLEN-1:0]         out_data_o,
  output logic [TAG_W-1:0]        out_tag_o,
  output logic                    busy_o
);
  localparam int LOG     = $clog2(XLEN);
  localparam int HW      = XLEN / 2;
  localparam bit WORD_OK = (WORD_EN != 0) && (XLEN == 64);

  function automatic logic [XLEN-1:0] f_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

  function automatic logic f_is_right(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd4);
  endfunction

  function automatic logic f_is_rot(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4);
  endfunction

  function automatic logic [XLEN-1:0] f_finish(input logic [XLEN-1:0] v, input logic [2:0] op,
                                                input logic word, input logic [LOG-1:0] cnt,
                                                input logic sign);
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] m;
    logic [HW-1:0]   m_lo;
    r    = f_is_right(op) ? f_rev(v) : v;
    m_lo = {HW{1'b1}} >> cnt;
    m    = word ? {{HW{1'b0}}, m_lo} : ({XLEN{1'b1}} >> cnt);
    if ((op == 3'd2) && sign) r = r | ~m;
    else r = r;
    if (word) r = {{HW{r[HW-1]}}, r[HW-1:0]};
    else r = r;
    if (op > 3'd4) r = {XLEN{1'b0}};
    else r = r;
    return r;
  endfunction

  logic                w_adv;
  logic                w_word;
  logic                w_sign;
  logic [LOG-1:0]      w_cnt;
  logic [XLEN-1:0]     w_x;
  logic [XLEN-1:0]     w_pre;
  logic [STAGES-1:0]   w_q_valid;
  logic [STAGES-1:0]   w_q_word;
  logic [STAGES-1:0]   w_q_sign;
  logic [2:0]          w_q_op   [STAGES];
  logic [LOG-1:0]      w_q_cnt  [STAGES];
  logic [TAG_W-1:0]    w_q_tag  [STAGES];
  logic [XLEN-1:0]     w_q_data [STAGES];

  assign w_adv      = ~out_valid_o | out_ready_i;
  assign in_ready_o = w_adv & ~flush_i;
  assign w_word     = WORD_OK & in_word_i;
  assign w_cnt      = w_word ? (in_count_i & LOG'(HW - 1)) : in_count_i;
  assign w_sign     = w_word ? in_num_i[HW-1] : in_num_i[XLEN-1];

  // Word rotates replicate the low half so a full-width rotate wraps within 32 bits.
  always_comb begin
    if (w_word && f_is_rot(in_op_i)) w_x = {in_num_i[HW-1:0], in_num_i[HW-1:0]};
    else if (w_word) w_x = {{HW{1'b0}}, in_num_i[HW-1:0]};
    else w_x = in_num_i;
    w_pre = f_is_right(in_op_i) ? f_rev(w_x) : w_x;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             r_valid, r_word, r_sign;
    logic [2:0]       r_op;
    logic [LOG-1:0]   r_cnt;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_data;
    logic             w_valid_in, w_word_in, w_sign_in;
    logic [2:0]       w_op_in;
    logic [LOG-1:0]   w_cnt_in;
    logic [TAG_W-1:0] w_tag_in;
    logic [XLEN-1:0]  w_data_in, w_data_nx;

    if (s == 0) begin : g_head
      assign w_valid_in = in_valid_i;
      assign w_word_in  = w_word;
      assign w_sign_in  = w_sign;
      assign w_op_in    = in_op_i;
      assign w_cnt_in   = w_cnt;
      assign w_tag_in   = in_tag_i;
      assign w_data_in  = w_pre;
    end else begin : g_body
      assign w_valid_in = w_q_valid[s-1];
      assign w_word_in  = w_q_word[s-1];
      assign w_sign_in  = w_q_sign[s-1];
      assign w_op_in    = w_q_op[s-1];
      assign w_cnt_in   = w_q_cnt[s-1];
      assign w_tag_in   = w_q_tag[s-1];
      assign w_data_in  = w_q_data[s-1];
    end

    // Barrel levels owned by this stage; the last stage also applies the output fix-up.
    always_comb begin
      w_data_nx = w_data_in;
      for (int k = 0; k < LOG; k++) begin
        if ((((k * STAGES) / LOG) == s) && w_cnt_in[k]) begin
          if (f_is_rot(w_op_in)) w_data_nx = (w_data_nx << (2**k)) | (w_data_nx >> (XLEN - 2**k));
          else w_data_nx = w_data_nx << (2**k);
        end else begin
          w_data_nx = w_data_nx;
        end
      end
      if (s == STAGES - 1) w_data_nx = f_finish(w_data_nx, w_op_in, w_word_in, w_cnt_in, w_sign_in);
      else w_data_nx = w_data_nx;
    end

    // Stage register: moves on the global enable; flush kills valid but keeps the payload.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_word  <= 1'b0;
        r_sign  <= 1'b0;
        r_op    <= 3'd0;
        r_cnt   <= {LOG{1'b0}};
        r_tag   <= {TAG_W{1'b0}};
        r_data  <= {XLEN{1'b0}};
      end else begin
        if (flush_i) r_valid <= 1'b0;
        else if (w_adv) r_valid <= w_valid_in;
        else r_valid <= r_valid;
        if (w_adv && !flush_i) begin
          r_word <= w_word_in;
          r_sign <= w_sign_in;
          r_op   <= w_op_in;
          r_cnt  <= w_cnt_in;
          r_tag  <= w_tag_in;
          r_data <= w_data_nx;
        end
      end
    end

    assign w_q_valid[s] = r_valid;
    assign w_q_word[s]  = r_word;
    assign w_q_sign[s]  = r_sign;
    assign w_q_op[s]    = r_op;
    assign w_q_cnt[s]   = r_cnt;
    assign w_q_tag[s]   = r_tag;
    assign w_q_data[s]  = r_data;
  end

  assign out_valid_o = w_q_valid[STAGES-1];
  assign out_data_o  = w_q_data[STAGES-1];
  assign out_tag_o   = w_q_tag[STAGES-1];
  assign busy_o      = |w_q_valid;

endmodule

// File: tb/tb_ysyx_041514_alu_shift_pipe.sv
// Directed bench for the pipelined shifter: three instances (STAGES 3, 1, 6) share
// one stimulus stream and are checked against hand values and a behavioural model.
module tb_ysyx_041514_alu_shift_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_word, flush, out_ready;
  logic [2:0]  in_op;
  logic [63:0] in_num;
  logic [5:0]  in_count;
  logic [4:0]  in_tag;
  logic        rdy [3];
  logic        ov  [3];
  logic        bsy [3];
  logic [63:0] od  [3];
  logic [4:0]  ot  [3];
  int          stg [3] = '{3, 1, 6};
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ysyx_041514_alu_shift_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5), .WORD_EN(1)) u_s3 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[0]), .in_op_i(in_op),
    .in_word_i(in_word), .in_num_i(in_num), .in_count_i(in_count), .in_tag_i(in_tag),
    .flush_i(flush), .out_valid_o(ov[0]), .out_ready_i(out_ready), .out_data_o(od[0]),
    .out_tag_o(ot[0]), .busy_o(bsy[0]));
  ysyx_041514_alu_shift_pipe #(.XLEN(64), .STAGES(1), .TAG_W(5), .WORD_EN(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[1]), .in_op_i(in_op),
    .in_word_i(in_word), .in_num_i(in_num), .in_count_i(in_count), .in_tag_i(in_tag),
    .flush_i(flush), .out_valid_o(ov[1]), .out_ready_i(out_ready), .out_data_o(od[1]),
    .out_tag_o(ot[1]), .busy_o(bsy[1]));
  ysyx_041514_alu_shift_pipe #(.XLEN(64), .STAGES(6), .TAG_W(5), .WORD_EN(1)) u_s6 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[2]), .in_op_i(in_op),
    .in_word_i(in_word), .in_num_i(in_num), .in_count_i(in_count), .in_tag_i(in_tag),
    .flush_i(flush), .out_valid_o(ov[2]), .out_ready_i(out_ready), .out_data_o(od[2]),
    .out_tag_o(ot[2]), .busy_o(bsy[2]));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Straightforward reference semantics, written directly on 32/64-bit values.
  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] num, input logic [5:0] cnt);
    logic [31:0] a, r32;
    logic [63:0] r;
    int c;
    r32 = 32'd0;
    r   = 64'd0;
    if (w) begin
      a = num[31:0];
      c = int'(cnt[4:0]);
      case (op)
        3'd0: r32 = a << c;
        3'd1: r32 = a >> c;
        3'd2: r32 = 32'($signed(a) >>> c);
        3'd3: r32 = (c == 0) ? a : ((a << c) | (a >> (32 - c)));
        3'd4: r32 = (c == 0) ? a : ((a >> c) | (a << (32 - c)));
        default: return 64'd0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    c = int'(cnt);
    case (op)
      3'd0: r = num << c;
      3'd1: r = num >> c;
      3'd2: r = 64'($signed(num) >>> c);
      3'd3: r = (c == 0) ? num : ((num << c) | (num >> (64 - c)));
      3'd4: r = (c == 0) ? num : ((num >> c) | (num << (64 - c)));
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Called at a negedge with all instances idle; checks latency, data and tag of each.
  task automatic run_one(input logic [2:0] op, input logic w, input logic [63:0] num,
                         input logic [5:0] cnt, input logic [4:0] tag,
                         input logic [63:0] exp, input string name);
    int          lat [3];
    logic [63:0] d   [3];
    logic [4:0]  t   [3];
    for (int j = 0; j < 3; j++) begin
      lat[j] = -1;
      d[j]   = 64'd0;
      t[j]   = 5'd0;
    end
    in_op = op; in_word = w; in_num = num; in_count = cnt; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      for (int j = 0; j < 3; j++) begin
        if (ov[j] && lat[j] < 0) begin
          lat[j] = cyc;
          d[j]   = od[j];
          t[j]   = ot[j];
        end
      end
      @(negedge clk);
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s/S%0d latency", name, stg[j]), 64'(lat[j]), 64'(stg[j]));
      chk($sformatf("%s/S%0d data", name, stg[j]), d[j], exp);
      chk($sformatf("%s/S%0d tag", name, stg[j]), 64'(t[j]), 64'(tag));
    end
  endtask

  task automatic stream();
    logic [63:0] exp_d [8];
    logic [4:0]  exp_t [8];
    int          idx   [3];
    int          n_sent;
    n_sent = 0;
    for (int j = 0; j < 3; j++) idx[j] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (n_sent == 8 && idx[0] == 8 && idx[1] == 8 && idx[2] == 8) break;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      for (int j = 0; j < 3; j++) begin
        if (ov[j] && !out_ready) chk($sformatf("stall S%0d in_ready", stg[j]), 64'(rdy[j]), 64'd0);
        if (ov[j] && out_ready) begin
          if (idx[j] < 8) begin
            chk($sformatf("stream S%0d #%0d data", stg[j], idx[j]), od[j], exp_d[idx[j]]);
            chk($sformatf("stream S%0d #%0d tag", stg[j], idx[j]), 64'(ot[j]), 64'(exp_t[idx[j]]));
          end else begin
            chk($sformatf("stream S%0d extra result index", stg[j]), 64'(idx[j]), 64'd7);
          end
          idx[j]++;
        end
      end
      if (n_sent < 8 && rdy[0] && rdy[1] && rdy[2]) begin
        in_op    = 3'($urandom_range(0, 7));
        in_word  = 1'($urandom_range(0, 1));
        in_num   = {$urandom, $urandom};
        in_count = 6'($urandom_range(0, 63));
        in_tag   = 5'($urandom_range(0, 31));
        in_valid = 1'b1;
        exp_d[n_sent] = model(in_op, in_word, in_num, in_count);
        exp_t[n_sent] = in_tag;
        n_sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) chk($sformatf("stream S%0d result count", stg[j]), 64'(idx[j]), 64'd8);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_word = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_op = 3'd0; in_num = 64'd0; in_count = 6'd0; in_tag = 5'd0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("reset S%0d out_valid", stg[j]), 64'(ov[j]), 64'd0);
      chk($sformatf("reset S%0d out_data", stg[j]), od[j], 64'd0);
      chk($sformatf("reset S%0d out_tag", stg[j]), 64'(ot[j]), 64'd0);
      chk($sformatf("reset S%0d busy", stg[j]), 64'(bsy[j]), 64'd0);
    end
    rst = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) chk($sformatf("post-reset S%0d in_ready", stg[j]), 64'(rdy[j]), 64'd1);
    @(negedge clk);

    run_one(3'd2, 1'b0, 64'h8000_0000_0000_0010, 6'd4, 5'd1, 64'hF800_0000_0000_0001, "sra4");
    run_one(3'd0, 1'b0, 64'h0000_0000_0000_0001, 6'd63, 5'd2, 64'h8000_0000_0000_0000, "sll63");
    run_one(3'd4, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd0, 5'd3, 64'h0123_4567_89AB_CDEF, "cnt0");
    run_one(3'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'd36, 5'd4, 64'h0000_0000_0800_0000, "srlw36");
    run_one(3'd2, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'd36, 5'd5, 64'hFFFF_FFFF_F800_0000, "sraw36");
    run_one(3'd0, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'd1, 5'd6, 64'h0000_0000_0000_0000, "sllw1");
    run_one(3'd4, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd8, 5'd7, 64'hEF01_2345_6789_ABCD, "ror8");
    run_one(3'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd56, 5'd8, 64'hEF01_2345_6789_ABCD, "rol56");
    run_one(3'd4, 1'b1, 64'h0123_4567_89AB_CDEF, 6'd8, 5'd9, 64'hFFFF_FFFF_EF89_ABCD, "rorw8");
    run_one(3'd5, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd8, 5'h1A, 64'h0000_0000_0000_0000, "rsvd101");

    stream();
    repeat (2) @(negedge clk);

    // Flush with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      in_op = 3'd0; in_word = 1'b0; in_num = 64'(i + 1); in_count = 6'd1; in_tag = 5'(i + 20);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) chk($sformatf("flush S%0d in_ready", stg[j]), 64'(rdy[j]), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("flush S%0d busy", stg[j]), 64'(bsy[j]), 64'd0);
      chk($sformatf("flush S%0d out_valid", stg[j]), 64'(ov[j]), 64'd0);
    end
    run_one(3'd4, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd8, 5'd11, 64'hEF01_2345_6789_ABCD, "post-flush");

    // Fill every instance with stalled results, then reset asynchronously.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_op = 3'd0; in_word = 1'b0; in_num = 64'd1; in_count = 6'd4; in_tag = 5'd7;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("pre-reset S%0d out_valid", stg[j]), 64'(ov[j]), 64'd1);
      chk($sformatf("pre-reset S%0d out_data", stg[j]), od[j], 64'h10);
    end
    #2 rst = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("async-reset S%0d out_valid", stg[j]), 64'(ov[j]), 64'd0);
      chk($sformatf("async-reset S%0d out_data", stg[j]), od[j], 64'd0);
      chk($sformatf("async-reset S%0d out_tag", stg[j]), 64'(ot[j]), 64'd0);
      chk($sformatf("async-reset S%0d busy", stg[j]), 64'(bsy[j]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) chk($sformatf("release S%0d in_ready", stg[j]), 64'(rdy[j]), 64'd1);
    @(negedge clk);
    run_one(3'd1, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 5'd13, 64'h0000_0000_0000_0001, "srl63");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_041514_alu_shift_pipe.md
# ysyx_041514_alu_shift_pipe

Parametrised, pipelined shift/rotate unit for the ALU that supersedes the single-cycle combinational shifter on timing-critical configurations. It supports logical left, logical right, arithmetic right, rotate left and rotate right, plus an RV64 word mode with sign-extended 32-bit results. The shift is split across `STAGES` register stages behind a valid/ready handshake with backpressure and flush. It sits between the EX issue logic and the writeback mux.

## Interface
- `XLEN`, default 64: datapath width; must be a power of two, ≥ 8.
- `STAGES`, default 2: pipeline depth, from 1 to `LOG` (`LOG` = clog2(`XLEN`)).
- `TAG_W`, default 5: width of the sideband tag (e.g. rd index), passed through unchanged.
- `WORD_EN`, default 1: word mode is legal only when `XLEN` = 64; when 0, `in_word_i` is ignored.
- `clk`, in, 1: the single clock; all state is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid_i`, in, 1: request valid.
- `in_ready_o`, out, 1: request accepted when `in_valid_i & in_ready_o` is high at the rising edge.
- `in_op_i`, in, 3: 000 sll, 001 srl, 010 sra, 011 rol, 100 ror; 101–111 are reserved.
- `in_word_i`, in, 1: 32-bit word operation (sllw/srlw/sraw/rolw/rorw).
- `in_num_i`, in, `XLEN`: operand.
- `in_count_i`, in, `LOG`: shift amount.
- `in_tag_i`, in, `TAG_W`: sideband tag.
- `flush_i`, in, 1: synchronous kill of all in-flight operations.
- `out_valid_o`, out, 1: result valid.
- `out_ready_i`, in, 1: consumer accepts the result.
- `out_data_o`, out, `XLEN`: result.
- `out_tag_o`, out, `TAG_W`: tag of the result.
- `busy_o`, out, 1: OR of all stage valid bits.

## Operation
- **Effective count.**
  - Word mode: `in_count_i[4:0]`.
  - Otherwise: the full `in_count_i` (modulo `XLEN`).
- **Effective operand.**
  - Word mode: the low 32 bits, zero-extended to 64.
  - Sign bit for sra: `num[31]` in word mode, otherwise `num[XLEN-1]`.
- **Functional result, with W = 32 in word mode, else `XLEN`, and c = effective count.**
  - sll: x << c.
  - srl: x >> c.
  - sra: x >> c, with the vacated top c bits of the W-bit field filled with the sign bit.
  - rol: (x << c) | (x >> (W-c)) within W bits.
  - ror: (x >> c) | (x << (W-c)) within W bits.
  - c = 0 returns x unchanged for every op.
- **Word-mode output.** Bits [31:0] of the result, sign-extended from bit 31 to 64 bits. This applies to all five ops, including srlw and sllw.
- **Reserved op.** Codes 101–111 produce `out_data_o` = 0; the tag still flows through.
- **Datapath.**
  - One left-shift/rotate barrel with `LOG` levels; level k shifts by 2^k.
  - Right ops bit-reverse the operand on entry and bit-reverse the result on exit.
  - The sra fill uses a mask of all-ones >> c within W bits.
  - Level k is registered into stage floor(k·`STAGES`/`LOG`).
  - Operand reverse happens in stage 0; output reverse, sign mask and sign extension happen in the last stage before its register.
- **Pipeline control.**
  - Single global enable: `adv` = ~`out_valid_o` | `out_ready_i`.
  - On `adv`, every stage moves forward, together with its valid bit, op, word, count-remaining, sign and tag.
  - `in_ready_o` = `adv` & ~`flush_i`.
  - Bubbles propagate as invalid stages and are collapsed only at the output.
- **Flush.** When `flush_i` is high at an edge, all stage valid bits clear and the input is not accepted. Data and tag registers keep their contents.
- **Ordering.** Results leave in acceptance order; none is lost or duplicated.

## Timing
- **Latency.** A request accepted at edge N produces `out_valid_o` = 1 after edge N+`STAGES`, provided `adv` held throughout.
- **Throughput.** One result per cycle while `out_ready_i` = 1.
- **Stall.** While `out_valid_o` & ~`out_ready_i`, all stages hold, `in_ready_o` = 0, and `out_data_o`/`out_tag_o` stay stable.
- **Outputs while valid.** `out_data_o` and `out_tag_o` change only on an edge where `adv` = 1.
- **Reset values.**
  - All valid bits 0, so `out_valid_o` = 0 and `busy_o` = 0.
  - `out_data_o` = 0 and `out_tag_o` = 0.
  - `in_ready_o` = 1 once `rst` deasserts (0 while `flush_i`).
  - Reset asserted mid-operation discards everything in flight immediately and asynchronously.
- **Simultaneous flush and output handshake.** If `flush_i` and `out_valid_o & out_ready_i` are high on the same edge, the output handshake completes (the consumer has taken the result) and the remaining stages are killed.
- **STAGES = 1.** Acts as a registered single-cycle shifter: latency 1, `in_ready_o` = ~`out_valid_o` | `out_ready_i`.

## Test plan
All scenarios use `XLEN` = 64 and `STAGES` = 3 unless noted.
- **Latency and sra.** sra 0x8000_0000_0000_0010 by 4 → 0xF800_0000_0000_0001, with `out_valid_o` exactly 3 cycles after accept; sll of 1 by 63 → 0x8000_0000_0000_0000; count 0 returns the operand.
- **Word mode.** Operand 0xFFFF_FFFF_8000_0000 with count 36:
  - srlw → 0x0000_0000_0800_0000 (count masked to 4).
  - sraw → 0xFFFF_FFFF_F800_0000.
  - sllw by 1 → 0x0000_0000_0000_0000.
- **Rotates.**
  - ror 0x0123_4567_89AB_CDEF by 8 → 0xEF01_2345_6789_ABCD.
  - rol by 56 → same value.
  - rorw by 8 → 0xFFFF_FFFF_EF89_ABCD.
  - op 101 → 0 with the tag preserved.
- **Backpressure.** Stream 8 random ops with `out_ready_i` toggled randomly; check all 8 results and tags against a model, in order, with no duplicates. Check `in_ready_o` = 0 whenever `out_valid_o` & ~`out_ready_i`.
- **Flush.** 3 ops in flight, pulse `flush_i` → next cycle `busy_o` = 0 and `out_valid_o` = 0. An op accepted on the following cycle emerges 3 cycles later with the correct value.
- **Reset and STAGES = 1.** Assert `rst` asynchronously mid-stream → `out_valid_o`, `out_data_o` and `out_tag_o` drop to 0 immediately. Rerun the same random stream with `STAGES` = 1 and `STAGES` = 6; results must match the model.
